issue_controller: RTL and testbench
===================================

Name: issue_controller

Overview:
- Tomasulo issue stage between the instruction queue and the reservation stations / load-store buffers.
- Accepts one decoded instruction per cycle (opcode, RX, RY, RZ, immediate).
- Allocates a free station of the matching class, reads operands or producer tags through the register status table, and drives stall back to the queue.
- Snoops the common data bus (CDB) to free stations, clear register status, forward results and generate register-file writeback.

Parameters:
DATA_W, 16, operand/result width
N_ARITH, 3, ADD/SUB reservation stations, tags 1..N_ARITH
N_MEM, 2, LD/SD buffers, tags N_ARITH+1..N_ARITH+N_MEM
TAG_W, 3, tag width; tag 0 = "value ready / no producer"

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
instr_valid  in  1  queue presents an instruction
opcode  in  3  000 ADD, 001 SUB, 010 LD, 011 SD, 1xx illegal
rx  in  3  ADD/SUB/LD destination; SD store-data source
ry  in  3  first source / LD-SD base
rz  in  3  ADD/SUB second source
immediate  in  4  LD/SD offset, passed through
stall  out  1  combinational; instruction not accepted this cycle
rf_ra_j  out  3  combinational = ry
rf_ra_k  out  3  combinational = rx if SD, else rz
rf_rd_j  in  DATA_W  register-file data for rf_ra_j
rf_rd_k  in  DATA_W  register-file data for rf_ra_k
iss_valid  out  1  registered, one-cycle issue strobe
iss_tag  out  TAG_W  allocated station
iss_op  out  3  opcode
iss_dest  out  3  destination register (0 for SD)
iss_vj, iss_vk  out  DATA_W  operand values (valid when q=0)
iss_qj, iss_qk  out  TAG_W  producer tags
iss_imm  out  4  immediate
cdb_valid  in  1  CDB broadcast
cdb_tag  in  TAG_W  producing station
cdb_data  in  DATA_W  result
rf_we  out  1  combinational register writeback enable
rf_waddr  out  3  register to write
rf_wdata  out  DATA_W  = cdb_data

Behaviour:
- State: busy bit per station; Qi[0..7] register status, TAG_W bits each.
- Reset: all busy=0, all Qi=0, every registered output 0. Reset mid-operation discards all in-flight state. No CDB action in a reset cycle.
- Class: ADD/SUB → arith; LD/SD → mem.
- stall = instr_valid & legal opcode & no free station in class. Computed from registered busy bits only: a station freed by CDB this cycle is not reusable until the next cycle.
- Accept: instr_valid & !stall at posedge.
- On accepting a legal instruction:
  - Allocate lowest-index free station of the class; set busy; issue next cycle (latency 1).
  - Operand j (source ry): if Qi[ry]=0 → vj=rf_rd_j, qj=0. Else if cdb_valid & cdb_tag=Qi[ry] → vj=cdb_data, qj=0 (bypass). Else qj=Qi[ry], vj=0.
  - Operand k (source rz, or rx for SD): resolved the same way. For LD, qk=0 and vk=0.
  - Destination (ADD/SUB/LD): Qi[rx] ← new tag. Sources are resolved with pre-update Qi, so ADD R1,R1,R1 reads R1's previous producer.
- Illegal opcode: consumed (never stalls), no allocation, iss_valid=0.
- iss_valid=0 when nothing is accepted; other iss_* outputs hold their values.
- CDB (cdb_valid):
  - busy[cdb_tag] ← 0.
  - Every r with Qi[r]=cdb_tag → Qi[r] ← 0, unless the same-cycle issue writes Qi[r]; the new tag wins.
  - rf_we=1, rf_waddr=r for the (at most one) r with pre-update Qi[r]=cdb_tag; otherwise rf_we=0. SD never owns a Qi entry.
  - cdb_tag 0 or unallocated: ignored, except freeing a non-busy station is a no-op.

Test Plan:
- Reset; ADD R0,R1,R2 with rf_rd_j=5, rf_rd_k=7 → next cycle iss_valid=1, tag=1, vj=5, vk=7, qj=qk=0, dest=0; Qi[0]=1.
- Then SUB R1,R0,R1 → tag=2, qj=1, vk=rf value, qk=0; Qi[1]=2. ADD R2,R2,R2 → tag=3.
- Fourth ADD with 3 arith busy → stall=1 held, no iss_valid. CDB tag=2 → stall still 1 that cycle; next cycle stall=0 and issue gets tag=2.
- Instruction reads R0 (Qi[0]=1) while CDB tag=1, data=0x00AA → qj=0, vj=0x00AA; rf_we=1, rf_waddr=0, rf_wdata=0x00AA; Qi[0]=0.
- Issue ADD R0,.. (new tag 3) in the same cycle as CDB tag=1 (old R0 producer) → rf_we=1, rf_waddr=0; Qi[0]=3, not 0.
- LD R3,(R1+4) then SD R3,(R2+1) → SD tags 4/5, SD qk=4; third mem op stalls. Opcode 110 → consumed, no issue. Reset mid-stream → stall=0, Qi and busy cleared, iss_valid=0.

Source files
------------

// File: rtl/issue_controller_if.sv
// Issue-stage bundle: instruction queue, register file, reservation-station issue and CDB signals.
interface issue_controller_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 3
);
  logic              instr_valid;
  logic [2:0]        opcode;
  logic [2:0]        rx;
  logic [2:0]        ry;
  logic [2:0]        rz;
  logic [3:0]        immediate;
  logic              stall;
  logic [2:0]        rf_ra_j;
  logic [2:0]        rf_ra_k;
  logic [DATA_W-1:0] rf_rd_j;
  logic [DATA_W-1:0] rf_rd_k;
  logic              iss_valid;
  logic [TAG_W-1:0]  iss_tag;
  logic [2:0]        iss_op;
  logic [2:0]        iss_dest;
  logic [DATA_W-1:0] iss_vj;
  logic [DATA_W-1:0] iss_vk;
  logic [TAG_W-1:0]  iss_qj;
  logic [TAG_W-1:0]  iss_qk;
  logic [3:0]        iss_imm;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport slave (
    input  instr_valid, opcode, rx, ry, rz, immediate, rf_rd_j, rf_rd_k,
           cdb_valid, cdb_tag, cdb_data,
    output stall, rf_ra_j, rf_ra_k, iss_valid, iss_tag, iss_op, iss_dest,
           iss_vj, iss_vk, iss_qj, iss_qk, iss_imm, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output instr_valid, opcode, rx, ry, rz, immediate, rf_rd_j, rf_rd_k,
           cdb_valid, cdb_tag, cdb_data,
    input  stall, rf_ra_j, rf_ra_k, iss_valid, iss_tag, iss_op, iss_dest,
           iss_vj, iss_vk, iss_qj, iss_qk, iss_imm, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/issue_controller.sv
// Tomasulo issue stage: station allocation, register-status renaming and CDB snooping.
// DATA_W/TAG_W must match the widths of the connected issue_controller_if instance.
module issue_controller #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned N_ARITH = 3,
  parameter int unsigned N_MEM   = 2,
  parameter int unsigned TAG_W   = 3
) (
  input logic               clock,
  input logic               reset,
  issue_controller_if.slave bus
);
  localparam int unsigned N_ST  = N_ARITH + N_MEM;
  localparam int unsigned N_REG = 8;

  logic [N_ST-1:0]   busy;
  logic [TAG_W-1:0]  qi [N_REG];

  logic              is_legal, is_mem, is_ld, is_sd;
  logic              alloc_found;
  logic [TAG_W-1:0]  alloc_tag;
  logic [2:0]        src_k;
  logic [TAG_W-1:0]  qj_raw, qk_raw;
  logic [DATA_W-1:0] vj_c, vk_c;
  logic [TAG_W-1:0]  qj_c, qk_c;
  logic              cdb_act, accept;

  assign is_legal = ~bus.opcode[2];
  assign is_mem   = bus.opcode[1];
  assign is_ld    = (bus.opcode == 3'b010);
  assign is_sd    = (bus.opcode == 3'b011);
  assign src_k    = is_sd ? bus.rx : bus.rz;
  assign qj_raw   = qi[bus.ry];
  assign qk_raw   = qi[src_k];
  assign cdb_act  = bus.cdb_valid & ~reset & (bus.cdb_tag != '0);

  assign bus.rf_ra_j  = bus.ry;
  assign bus.rf_ra_k  = src_k;
  assign bus.stall    = bus.instr_valid & is_legal & ~alloc_found;
  assign accept       = bus.instr_valid & is_legal & alloc_found;
  assign bus.rf_wdata = bus.cdb_data;

  // Lowest-index free station of the instruction's class, from registered busy bits only.
  always_comb begin
    alloc_found = 1'b0;
    alloc_tag   = '0;
    for (int unsigned i = 0; i < N_ST; i++) begin
      if (!alloc_found && !busy[i] && ((i >= N_ARITH) == is_mem)) begin
        alloc_found = 1'b1;
        alloc_tag   = TAG_W'(i + 1);
      end
    end
  end

  // Operand resolution with same-cycle CDB bypass.
  always_comb begin
    vj_c = '0;
    qj_c = '0;
    if (qj_raw == '0) begin
      vj_c = bus.rf_rd_j;
    end else if (cdb_act && bus.cdb_tag == qj_raw) begin
      vj_c = bus.cdb_data;
    end else begin
      qj_c = qj_raw;
    end

    vk_c = '0;
    qk_c = '0;
    if (!is_ld) begin
      if (qk_raw == '0) begin
        vk_c = bus.rf_rd_k;
      end else if (cdb_act && bus.cdb_tag == qk_raw) begin
        vk_c = bus.cdb_data;
      end else begin
        qk_c = qk_raw;
      end
    end
  end

  // Writeback target: the register whose pending producer is broadcasting.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    for (int unsigned r = 0; r < N_REG; r++) begin
      if (!bus.rf_we && cdb_act && qi[r] == bus.cdb_tag) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = 3'(r);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy          <= '0;
      bus.iss_valid <= 1'b0;
      bus.iss_tag   <= '0;
      bus.iss_op    <= '0;
      bus.iss_dest  <= '0;
      bus.iss_vj    <= '0;
      bus.iss_vk    <= '0;
      bus.iss_qj    <= '0;
      bus.iss_qk    <= '0;
      bus.iss_imm   <= '0;
      for (int unsigned r = 0; r < N_REG; r++) qi[r] <= '0;
    end else begin
      bus.iss_valid <= accept;
      if (accept) begin
        bus.iss_tag  <= alloc_tag;
        bus.iss_op   <= bus.opcode;
        bus.iss_dest <= is_sd ? 3'b000 : bus.rx;
        bus.iss_vj   <= vj_c;
        bus.iss_vk   <= vk_c;
        bus.iss_qj   <= qj_c;
        bus.iss_qk   <= qk_c;
        bus.iss_imm  <= bus.immediate;
      end
      // Free on broadcast first so a new allocation in the same cycle takes precedence.
      for (int unsigned i = 0; i < N_ST; i++) begin
        if (cdb_act && bus.cdb_tag == TAG_W'(i + 1)) busy[i] <= 1'b0;
        if (accept && alloc_tag == TAG_W'(i + 1)) busy[i] <= 1'b1;
      end
      for (int unsigned r = 0; r < N_REG; r++) begin
        if (cdb_act && qi[r] == bus.cdb_tag) qi[r] <= '0;
        if (accept && !is_sd && bus.rx == 3'(r)) qi[r] <= alloc_tag;
      end
    end
  end
endmodule

// File: tb/tb_issue_controller.sv
// Directed bench for issue_controller: renaming, stalls, CDB bypass/writeback and reset.
module tb_issue_controller;
  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  issue_controller_if #(.DATA_W(16), .TAG_W(3)) bus ();

  issue_controller #(.DATA_W(16), .N_ARITH(3), .N_MEM(2), .TAG_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] x,
                       input logic [2:0] y, input logic [2:0] z, input logic [3:0] imm,
                       input logic [15:0] dj, input logic [15:0] dk);
    bus.instr_valid = v;
    bus.opcode      = op;
    bus.rx          = x;
    bus.ry          = y;
    bus.rz          = z;
    bus.immediate   = imm;
    bus.rf_rd_j     = dj;
    bus.rf_rd_k     = dk;
  endtask

  task automatic cdb(input logic v, input logic [2:0] t, input logic [15:0] d);
    bus.cdb_valid = v;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_iss(input string tag, input logic [2:0] t, input logic [2:0] op,
                           input logic [2:0] dest, input logic [15:0] vj, input logic [15:0] vk,
                           input logic [2:0] qj, input logic [2:0] qk);
    check({tag, ".valid"}, 32'(bus.iss_valid), 32'd1);
    check({tag, ".tag"},   32'(bus.iss_tag),   32'(t));
    check({tag, ".op"},    32'(bus.iss_op),    32'(op));
    check({tag, ".dest"},  32'(bus.iss_dest),  32'(dest));
    check({tag, ".vj"},    32'(bus.iss_vj),    32'(vj));
    check({tag, ".vk"},    32'(bus.iss_vk),    32'(vk));
    check({tag, ".qj"},    32'(bus.iss_qj),    32'(qj));
    check({tag, ".qk"},    32'(bus.iss_qk),    32'(qk));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0, 16'h0);
    cdb(1'b0, 3'd0, 16'h0);
    tick();
    tick();
    check("rst.iss_valid", 32'(bus.iss_valid), 32'd0);
    check("rst.iss_tag",   32'(bus.iss_tag),   32'd0);
    check("rst.iss_vj",    32'(bus.iss_vj),    32'd0);
    check("rst.stall",     32'(bus.stall),     32'd0);
    reset = 1'b0;

    // ADD R0,R1,R2 -> tag 1; Qi[0]=1
    drive(1'b1, 3'b000, 3'd0, 3'd1, 3'd2, 4'd0, 16'd5, 16'd7);
    #1;
    check("add0.ra_j",  32'(bus.rf_ra_j), 32'd1);
    check("add0.ra_k",  32'(bus.rf_ra_k), 32'd2);
    check("add0.stall", 32'(bus.stall),   32'd0);
    tick();
    check_iss("add0", 3'd1, 3'b000, 3'd0, 16'd5, 16'd7, 3'd0, 3'd0);

    // SUB R1,R0,R1 -> tag 2, waits on tag 1; Qi[1]=2
    drive(1'b1, 3'b001, 3'd1, 3'd0, 3'd1, 4'd0, 16'd9, 16'd11);
    tick();
    check_iss("sub1", 3'd2, 3'b001, 3'd1, 16'd0, 16'd11, 3'd1, 3'd0);

    // ADD R2,R2,R2 -> tag 3; Qi[2]=3
    drive(1'b1, 3'b000, 3'd2, 3'd2, 3'd2, 4'd0, 16'd3, 16'd4);
    tick();
    check_iss("add2", 3'd3, 3'b000, 3'd2, 16'd3, 16'd4, 3'd0, 3'd0);

    // ADD R4,R0,R1 with all arith stations busy
    drive(1'b1, 3'b000, 3'd4, 3'd0, 3'd1, 4'd0, 16'd1, 16'd2);
    #1;
    check("full.stall", 32'(bus.stall), 32'd1);
    tick();
    check("full.iss_valid", 32'(bus.iss_valid), 32'd0);
    check("full.iss_tag_hold", 32'(bus.iss_tag), 32'd3);

    // CDB frees tag 2 (R1 producer): still stalled this cycle, writeback to R1
    cdb(1'b1, 3'd2, 16'h0022);
    #1;
    check("cdb2.stall",    32'(bus.stall),    32'd1);
    check("cdb2.rf_we",    32'(bus.rf_we),    32'd1);
    check("cdb2.rf_waddr", 32'(bus.rf_waddr), 32'd1);
    check("cdb2.rf_wdata", 32'(bus.rf_wdata), 32'h0022);
    tick();
    check("cdb2.iss_valid", 32'(bus.iss_valid), 32'd0);

    // Freed station reused: ADD R4,R0,R1 -> tag 2, qj=1, R1 now from RF; Qi[4]=2
    cdb(1'b0, 3'd0, 16'h0);
    #1;
    check("reuse.stall", 32'(bus.stall), 32'd0);
    check("reuse.rf_we", 32'(bus.rf_we), 32'd0);
    tick();
    check_iss("reuse", 3'd2, 3'b000, 3'd4, 16'd0, 16'd2, 3'd1, 3'd0);

    // LD R3,(R0+4) while CDB broadcasts tag 1 -> bypass; Qi[0]=0, Qi[3]=4
    drive(1'b1, 3'b010, 3'd3, 3'd0, 3'd5, 4'd4, 16'h1234, 16'h0055);
    cdb(1'b1, 3'd1, 16'h00AA);
    #1;
    check("ldbyp.rf_we",    32'(bus.rf_we),    32'd1);
    check("ldbyp.rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("ldbyp.rf_wdata", 32'(bus.rf_wdata), 32'h00AA);
    tick();
    check_iss("ldbyp", 3'd4, 3'b010, 3'd3, 16'h00AA, 16'd0, 3'd0, 3'd0);
    check("ldbyp.imm", 32'(bus.iss_imm), 32'd4);

    // ADD R0,R0,R0 -> tag 1, R0 now clean in RF; Qi[0]=1
    drive(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 4'd0, 16'd6, 16'd6);
    cdb(1'b0, 3'd0, 16'h0);
    tick();
    check_iss("add00", 3'd1, 3'b000, 3'd0, 16'd6, 16'd6, 3'd0, 3'd0);

    // CDB tag 3 alone: writeback R2, frees station 3
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd0, 16'd0, 16'd0);
    cdb(1'b1, 3'd3, 16'h0033);
    #1;
    check("cdb3.rf_waddr", 32'(bus.rf_waddr), 32'd2);
    tick();
    check("cdb3.iss_valid", 32'(bus.iss_valid), 32'd0);

    // ADD R0,R2,R0 -> tag 3 while CDB retires old R0 producer tag 1; new tag wins
    drive(1'b1, 3'b000, 3'd0, 3'd2, 3'd0, 4'd0, 16'h0020, 16'h0099);
    cdb(1'b1, 3'd1, 16'h0011);
    #1;
    check("race.rf_we",    32'(bus.rf_we),    32'd1);
    check("race.rf_waddr", 32'(bus.rf_waddr), 32'd0);
    tick();
    check_iss("race", 3'd3, 3'b000, 3'd0, 16'h0020, 16'h0011, 3'd0, 3'd0);

    // SD R0,(R4+1): store data waits on tag 3, base on tag 2 -> tag 5
    drive(1'b1, 3'b011, 3'd0, 3'd4, 3'd6, 4'd1, 16'd0, 16'd0);
    cdb(1'b0, 3'd0, 16'h0);
    #1;
    check("sd.ra_k", 32'(bus.rf_ra_k), 32'd0);
    tick();
    check_iss("sd", 3'd5, 3'b011, 3'd0, 16'd0, 16'd0, 3'd2, 3'd3);
    check("sd.imm", 32'(bus.iss_imm), 32'd1);

    // Third memory op stalls
    drive(1'b1, 3'b010, 3'd6, 3'd1, 3'd0, 4'd2, 16'd0, 16'd0);
    #1;
    check("memfull.stall", 32'(bus.stall), 32'd1);
    tick();
    check("memfull.iss_valid", 32'(bus.iss_valid), 32'd0);

    // Illegal opcode consumed without issue
    drive(1'b1, 3'b110, 3'd1, 3'd1, 3'd1, 4'd0, 16'd0, 16'd0);
    #1;
    check("illegal.stall", 32'(bus.stall), 32'd0);
    tick();
    check("illegal.iss_valid", 32'(bus.iss_valid), 32'd0);

    // CDB tag 4 (LD) writes back R3
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd0, 16'd0, 16'd0);
    cdb(1'b1, 3'd4, 16'h0044);
    #1;
    check("cdb4.rf_waddr", 32'(bus.rf_waddr), 32'd3);
    tick();

    // Mid-stream reset: no CDB action, state cleared
    reset = 1'b1;
    cdb(1'b1, 3'd3, 16'h0077);
    drive(1'b1, 3'b000, 3'd1, 3'd0, 3'd4, 4'd0, 16'd1, 16'd2);
    #1;
    check("midrst.rf_we", 32'(bus.rf_we), 32'd0);
    tick();
    check("midrst.iss_valid", 32'(bus.iss_valid), 32'd0);
    check("midrst.iss_tag",   32'(bus.iss_tag),   32'd0);
    reset = 1'b0;
    cdb(1'b0, 3'd0, 16'h0);
    #1;
    check("midrst.stall", 32'(bus.stall), 32'd0);
    tick();
    check_iss("postrst", 3'd1, 3'b000, 3'd1, 16'd1, 16'd2, 3'd0, 3'd0);

    drive(1'b1, 3'b010, 3'd7, 3'd0, 3'd0, 4'd0, 16'h0005, 16'h0000);
    tick();
    check_iss("postrst.ld", 3'd4, 3'b010, 3'd7, 16'h0005, 16'd0, 3'd0, 3'd0);

    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd0, 16'd0, 16'd0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
